// File: rtl/rsa_arb_pkg.sv
// Shared types and sizing helpers for the RSA job arbiter.
// Imported by the round-robin picker and the arbiter top.
package rsa_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Requester index width; a single bit is kept even for degenerate sizes.
  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // WAIT timer width; wide enough to hold TIMEOUT itself so it can saturate there.
  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot grant plus the matching binary index.
module rsa_rr_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr is always below N_REQ, so a single subtract performs the wrap
      j = int'(ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one RSA modexp core between N_REQ requesters: round-robin pick, operand
// capture, ds pulse, bounded wait for ready, then a held response to the winner.
module rsa_job_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int W       = 2048,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  input  logic [N_REQ*W-1:0] req_exp,
  input  logic [N_REQ*W-1:0] req_mod,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic [W-1:0]       indata,
  output logic [W-1:0]       inExp,
  output logic [W-1:0]       inMod,
  output logic               ds,
  input  logic [W-1:0]       cypher,
  input  logic               ready,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int TMR_W = timer_w(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  // Handshakes: req[i] is a level held until gnt[i]; rsp_valid[id] is held with
  // rsp_data/rsp_err stable until the cycle rsp_ready[id] is sampled high.
  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   next_ptr;
  logic [TMR_W-1:0]  timer_q;
  logic [W-1:0]      indata_q, inexp_q, inmod_q;
  logic [W-1:0]      rsp_data_q;
  logic              rsp_err_q;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;

  logic              take;
  logic              hit;
  logic              expire;
  logic              done;

  rsa_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    hit     = 1'b0;
    expire  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          take    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        // ready has priority over an expiring timer in the same cycle
        if (ready) begin
          hit     = 1'b1;
          state_d = RESP;
        end else if (timer_q == TMR_LAST) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[id_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign next_ptr = (id_q == ID_LAST) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        id_q <= arb_idx;
      end
      if (done) begin
        rr_ptr_q <= next_ptr;
      end
      if (state_q == START) begin
        timer_q <= '0;
      end else if (state_q == WAIT && timer_q != TMR_SAT) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Core operands are only rewritten at the next grant, never cleared in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      indata_q <= '0;
      inexp_q  <= '0;
      inmod_q  <= '0;
    end else if (take) begin
      indata_q <= req_data[arb_idx*W +: W];
      inexp_q  <= req_exp[arb_idx*W +: W];
      inmod_q  <= req_mod[arb_idx*W +: W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (hit) begin
      rsp_data_q <= cypher;
      rsp_err_q  <= 1'b0;
    end else if (expire) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end
  end

  // gnt is masked while reset is asserted so every output reads 0 during reset.
  assign gnt       = (state_q == IDLE && !reset) ? arb_grant : '0;
  assign rsp_valid = (state_q == RESP) ? (N_REQ'(1) << id_q) : '0;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign indata    = indata_q;
  assign inExp     = inexp_q;
  assign inMod     = inmod_q;
  assign ds        = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
